// File: rtl/agc_sum_distributor.sv
// agc_sum_distributor: spreads each block sum over N fast-rate samples whose total equals the sum,
// using a one-entry pending buffer so that back-to-back blocks are emitted without a bubble.
module agc_sum_distributor #(
    parameter int IN_W   = 15,
    parameter int OUT_W  = 12,
    parameter int LOG2_N = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IN_W-1:0]  i_sum,
    input  logic             i_sum_valid,
    output logic             o_sum_ready,
    output logic [OUT_W-1:0] o_sample,
    output logic             o_sample_valid,
    input  logic             i_sample_ready,
    output logic             o_first,
    output logic             o_last,
    output logic             o_sat
);
    localparam int N = 1 << LOG2_N;
    localparam int CW = IN_W + OUT_W + 1;
    localparam logic [CW-1:0] SAT_MAX = CW'((2 ** OUT_W - 1) * N);
    logic            act_v, pend_v;
    logic [IN_W-1:0] act_s, pend_s;
    logic [LOG2_N:0] idx, r;
    logic [OUT_W:0]  q, beat;
    logic            sat, last, fire_in, fire_out, free;
    assign q = (OUT_W + 1)'(act_s >> LOG2_N);
    assign r = (LOG2_N + 1)'(act_s & IN_W'(N - 1));
    assign beat = q + (OUT_W + 1)'(idx < r);
    assign sat = CW'(act_s) > SAT_MAX;
    assign last = idx == (LOG2_N + 1)'(N - 1);
    assign fire_in = i_sum_valid && o_sum_ready;
    assign fire_out = act_v && i_sample_ready;
    assign free = !act_v || (fire_out && last);
    assign o_sum_ready = !pend_v;
    assign o_sample_valid = act_v;
    // Outputs derive only from registered state, so they hold while the sink stalls.
    assign o_sample = !act_v ? '0 : (sat || beat[OUT_W]) ? '1 : beat[OUT_W-1:0];
    assign o_first = act_v && idx == '0;
    assign o_last = act_v && last;
    assign o_sat = act_v && sat;
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            act_v  <= 1'b0;
            pend_v <= 1'b0;
            act_s  <= '0;
            pend_s <= '0;
            idx    <= '0;
        end else if (free) begin
            idx <= '0;
            if (pend_v) begin
                act_s  <= pend_s;
                act_v  <= 1'b1;
                pend_v <= 1'b0;
            end else if (fire_in) begin
                act_s <= i_sum;
                act_v <= 1'b1;
            end else begin
                act_v <= 1'b0;
            end
        end else begin
            if (fire_out) idx <= idx + 1'b1;
            if (fire_in) begin
                pend_s <= i_sum;
                pend_v <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_agc_sum_distributor.sv
// tb_agc_sum_distributor: directed plus randomized stimulus against a block-queue reference model.
module tb_agc_sum_distributor;
    localparam int N = 8;
    localparam int MAXV = 4095;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [14:0] i_sum = '0;
    logic        i_sum_valid = 1'b0;
    logic        i_sample_ready = 1'b0;
    logic        o_sum_ready, o_sample_valid, o_first, o_last, o_sat;
    logic [11:0] o_sample;
    int total = 0;
    int bad = 0;
    int blocks[$];
    int k = 0;

    agc_sum_distributor dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_sum(i_sum), .i_sum_valid(i_sum_valid),
        .o_sum_ready(o_sum_ready), .o_sample(o_sample), .o_sample_valid(o_sample_valid),
        .i_sample_ready(i_sample_ready), .o_first(o_first), .o_last(o_last), .o_sat(o_sat)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_beat(input int s, input int b);
        if (s > N * MAXV) return MAXV;
        return s / N + ((b < s % N) ? 1 : 0);
    endfunction

    task automatic step(input logic v, input int s, input logic rdy);
        logic mv, mr, fin, fout;
        @(negedge i_clk);
        mv = blocks.size() > 0;
        mr = blocks.size() < 2;
        check("valid", o_sample_valid, mv);
        check("ready", o_sum_ready, mr);
        if (mv) begin
            check("sample", o_sample, exp_beat(blocks[0], k));
            check("first", o_first, k == 0);
            check("last", o_last, k == N - 1);
            check("sat", o_sat, blocks[0] > N * MAXV);
        end
        i_sum_valid = v;
        i_sum = 15'(s);
        i_sample_ready = rdy;
        fin = v && mr;
        fout = mv && rdy;
        @(posedge i_clk);
        if (fout) begin
            k++;
            if (k == N) begin
                void'(blocks.pop_front());
                k = 0;
            end
        end
        if (fin) blocks.push_back(s);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && blocks.size() > 0; i++) step(0, 0, 1);
        step(0, 0, 1);
    endtask

    initial begin
        #1;
        check("rst_sample", o_sample, 0);
        check("rst_valid", o_sample_valid, 0);
        check("rst_first", o_first, 0);
        check("rst_last", o_last, 0);
        check("rst_sat", o_sat, 0);
        check("rst_ready", o_sum_ready, 1);
        @(negedge i_clk);
        i_rst = 1'b1;
        step(1, 100, 1);
        drain();
        step(1, 0, 1);
        drain();
        step(1, 7, 1);
        drain();
        step(1, 32760, 1);
        drain();
        step(1, 32767, 1);
        drain();
        step(1, 8, 1);
        step(1, 15, 1);
        for (int i = 0; i < 12; i++) step(1, 16, 1);
        drain();
        step(1, 100, 1);
        for (int i = 0; i < 10 && k != 2; i++) step(0, 0, 1);
        repeat (3) step(0, 0, 0);
        drain();
        step(1, 100, 1);
        step(1, 50, 1);
        for (int i = 0; i < 10 && k != 4; i++) step(0, 0, 1);
        #2;
        i_rst = 1'b0;
        #1;
        check("mid_rst_sample", o_sample, 0);
        check("mid_rst_valid", o_sample_valid, 0);
        check("mid_rst_first", o_first, 0);
        check("mid_rst_last", o_last, 0);
        check("mid_rst_sat", o_sat, 0);
        check("mid_rst_ready", o_sum_ready, 1);
        blocks.delete();
        k = 0;
        @(negedge i_clk);
        i_rst = 1'b1;
        step(1, 24, 1);
        drain();
        for (int i = 0; i < 3000; i++) begin
            int s;
            case ($urandom_range(0, 3))
                0: s = $urandom_range(0, 15);
                1: s = $urandom_range(32750, 32767);
                default: s = $urandom_range(0, 32767);
            endcase
            step(($urandom_range(0, 2) != 0), s, ($urandom_range(0, 3) != 0));
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
